mem_responder: RTL

- Memory-side responder for the core's instruction-refill and data-memory request interfaces; it serves the I-cache DataReq/MemReady handshake and the data-memory master port.
- Single-ported word RAM behind a one-request-at-a-time FSM with programmable response latency.
- Used as the simulation/FPGA memory under one hart and as the endpoint in core-level benches.

---
 rtl/mem_responder_if.sv | 35 +++
 rtl/mem_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response signal bundle for mem_responder
// Signal names are seen from the responder side; o_err exists only with MEM_RESPONDER_RANGE_ERR_EN.
interface mem_responder_if;
  logic        i_IC_DataReq;
  logic [31:0] i_IC_Addr;
  logic [31:0] o_IC_Instr;
  logic        o_IC_MemReady;
  logic        i_DM_MemRead;
  logic        i_DM_Wen;
  logic [31:0] i_DM_Addr;
  logic [3:0]  i_DM_byte_en;
  logic [31:0] i_DM_Wd;
  logic [31:0] o_DM_ReadData;
  logic        o_DM_Ready;
  logic        o_busy;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
  logic        o_err;
`endif

  modport slave (
    input  i_IC_DataReq, i_IC_Addr, i_DM_MemRead, i_DM_Wen, i_DM_Addr, i_DM_byte_en, i_DM_Wd,
    output o_IC_Instr, o_IC_MemReady, o_DM_ReadData, o_DM_Ready, o_busy
`ifdef MEM_RESPONDER_RANGE_ERR_EN
    , output o_err
`endif
  );

  modport master (
    output i_IC_DataReq, i_IC_Addr, i_DM_MemRead, i_DM_Wen, i_DM_Addr, i_DM_byte_en, i_DM_Wd,
    input  o_IC_Instr, o_IC_MemReady, o_DM_ReadData, o_DM_Ready, o_busy
`ifdef MEM_RESPONDER_RANGE_ERR_EN
    , input o_err
`endif
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port word RAM serving I-refill and data ports, one request at a time
// Optional macro MEM_RESPONDER_RANGE_ERR_EN: adds o_err, blocks out-of-range accesses, no wrap.
module mem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic            i_clk,
  input logic            i_rst,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_is_dm;
  logic          r_wr;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_be;
  logic [31:0]   r_wd;
  logic          r_ic_ready;
  logic          r_dm_ready;
  logic [31:0]   r_ic_instr;
  logic [31:0]   r_dm_rdata;

  logic          w_dm_req;
  logic [31:0]   w_req_addr;
  logic [AW-1:0] w_req_idx;
  logic          w_commit;
  logic [31:0]   w_rdata;

  // Data port has fixed priority; the accepted port's address picks the word.
  assign w_dm_req   = bus.i_DM_MemRead | bus.i_DM_Wen;
  assign w_req_addr = w_dm_req ? bus.i_DM_Addr : bus.i_IC_Addr;
  assign w_req_idx  = AW'((w_req_addr - BASE_ADDR) >> 2);

`ifdef MEM_RESPONDER_RANGE_ERR_EN
  logic r_oor;
  logic r_err;
  logic w_req_oor;

  assign w_req_oor = (w_req_addr - BASE_ADDR) >= 32'(4 * DEPTH_WORDS);
  assign w_commit  = (r_state == S_RESP) && r_wr && !r_oor && !i_rst;
  assign w_rdata   = r_oor ? 32'h0 : r_mem[r_idx];
  assign bus.o_err = r_err;
`else
  assign w_commit  = (r_state == S_RESP) && r_wr && !i_rst;
  assign w_rdata   = r_mem[r_idx];
`endif

  assign bus.o_IC_Instr    = r_ic_instr;
  assign bus.o_IC_MemReady = r_ic_ready;
  assign bus.o_DM_ReadData = r_dm_rdata;
  assign bus.o_DM_Ready    = r_dm_ready;
  assign bus.o_busy        = (r_state != S_IDLE);

  // RAM is never cleared; the read in the same edge sees the pre-write word.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_dm    <= 1'b0;
      r_wr       <= 1'b0;
      r_idx      <= '0;
      r_be       <= '0;
      r_wd       <= '0;
      r_ic_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_ic_instr <= '0;
      r_dm_rdata <= '0;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
      r_oor      <= 1'b0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_ic_ready <= 1'b0;
      r_dm_ready <= 1'b0;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_dm_req || bus.i_IC_DataReq) begin
            r_is_dm <= w_dm_req;
            r_wr    <= w_dm_req & bus.i_DM_Wen;
            r_idx   <= w_req_idx;
            r_be    <= bus.i_DM_byte_en;
            r_wd    <= bus.i_DM_Wd;
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? S_RESP : S_BUSY;
`ifdef MEM_RESPONDER_RANGE_ERR_EN
            r_oor   <= w_req_oor;
`endif
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (r_is_dm) begin
            r_dm_ready <= 1'b1;
            r_dm_rdata <= w_rdata;
          end else begin
            r_ic_ready <= 1'b1;
            r_ic_instr <= w_rdata;
          end
`ifdef MEM_RESPONDER_RANGE_ERR_EN
          r_err <= r_oor;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
